// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped timer peripheral:
// register offsets, TCON bit layout and the window decode helper.
package timer_pkg;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h4000_0000;

    localparam logic [3:0] TMR_TH      = 4'h0;
    localparam logic [3:0] TMR_TL      = 4'h4;
    localparam logic [3:0] TMR_TCON    = 4'h8;
    localparam logic [3:0] TMR_SYSTICK = 4'hC;

    localparam int TCON_EN    = 0;
    localparam int TCON_IRQEN = 1;
    localparam int TCON_IRQST = 2;
    localparam int TCON_W     = 3;

    // A hit needs the 16-byte window and a word-aligned byte address.
    function automatic logic addr_hit(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        return (addr[31:4] == base[31:4]) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/timer_bus_responder_tick_divider.sv
// Enable-gated prescaler: one tick every PRESCALE enabled cycles.
// The phase count holds while disabled so no tick is gained or lost.
module tick_divider #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    // With PRESCALE==1 the count stays at 0 and tick simply follows en.
    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/timer_bus_responder.sv
// Timer peripheral on the CPU data bus: TH/TL reload counter with
// interrupt, plus a free-running SYSTICK. Zero-wait-state reads.
module timer_bus_responder
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        IRQ
);

    logic [31:0]       th;
    logic [31:0]       tl;
    logic [31:0]       systick;
    logic [TCON_W-1:0] tcon;

    logic       hit;
    logic [3:0] off;
    logic       wr_th;
    logic       wr_tl;
    logic       wr_tcon;
    logic       tick;
    logic       ovf;

    assign hit     = addr_hit(address, BASE_ADDR);
    assign off     = {address[3:2], 2'b00};
    assign wr_th   = MemWrite && hit && (off == TMR_TH);
    assign wr_tl   = MemWrite && hit && (off == TMR_TL);
    assign wr_tcon = MemWrite && hit && (off == TMR_TCON);

    always_comb begin
        read_data = '0;
        if (MemRead && hit) begin
            unique case (off)
                TMR_TH:      read_data = th;
                TMR_TL:      read_data = tl;
                TMR_TCON:    read_data[TCON_W-1:0] = tcon;
                TMR_SYSTICK: read_data = systick;
                default:     read_data = '0;
            endcase
        end
    end

    tick_divider #(
        .PRESCALE(PRESCALE)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (tcon[TCON_EN]),
        .tick  (tick)
    );

    assign ovf = tick && (tl == 32'hFFFF_FFFF);

    always_ff @(posedge clk) begin
        if (!reset) begin
            th      <= '0;
            tl      <= '0;
            tcon    <= '0;
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;

            if (wr_th) begin
                th <= write_data;
            end

            // Reload uses the pre-edge TH even if TH is written now.
            if (wr_tl) begin
                tl <= write_data;
            end else if (tick) begin
                tl <= ovf ? th : tl + 32'd1;
            end

            // A same-edge overflow still sets status: set beats clear.
            if (wr_tcon) begin
                tcon[TCON_EN]    <= write_data[TCON_EN];
                tcon[TCON_IRQEN] <= write_data[TCON_IRQEN];
                tcon[TCON_IRQST] <= write_data[TCON_IRQST]
                                  | (ovf & tcon[TCON_IRQEN]);
            end else if (ovf && tcon[TCON_IRQEN]) begin
                tcon[TCON_IRQST] <= 1'b1;
            end
        end
    end

    assign IRQ = tcon[TCON_IRQEN] & tcon[TCON_IRQST];

endmodule

// File: tb/tb_timer_bus_responder.sv
// Directed bench for timer_bus_responder: a PRESCALE=1 instance for
// the bus/timer behaviour and a PRESCALE=4 instance for the divider.
module tb_timer_bus_responder;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] A_TH = BASE + 32'h0;
    localparam logic [31:0] A_TL = BASE + 32'h4;
    localparam logic [31:0] A_TC = BASE + 32'h8;
    localparam logic [31:0] A_ST = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd, wr;
    logic [31:0] addr, wdata, rdata;
    logic        irq;
    logic        rd4, wr4;
    logic [31:0] addr4, wdata4, rdata4;
    logic        irq4;

    int checks = 0;
    int failures = 0;
    logic [31:0] st0;

    always #5 clk = ~clk;

    timer_bus_responder #(
        .BASE_ADDR(BASE),
        .PRESCALE (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (rd),
        .MemWrite   (wr),
        .address    (addr),
        .write_data (wdata),
        .read_data  (rdata),
        .IRQ        (irq)
    );

    timer_bus_responder #(
        .BASE_ADDR(BASE),
        .PRESCALE (4)
    ) dut4 (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (rd4),
        .MemWrite   (wr4),
        .address    (addr4),
        .write_data (wdata4),
        .read_data  (rdata4),
        .IRQ        (irq4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input bit d4, input logic [31:0] a,
                          input logic [31:0] exp, input string tag);
        if (d4) begin
            rd4 = 1'b1; addr4 = a;
        end else begin
            rd = 1'b1; addr = a;
        end
        #1;
        chk(tag, d4 ? rdata4 : rdata, exp);
        rd = 1'b0; rd4 = 1'b0;
    endtask

    task automatic wr_reg(input bit d4, input logic [31:0] a,
                          input logic [31:0] d);
        if (d4) begin
            wr4 = 1'b1; addr4 = a; wdata4 = d;
        end else begin
            wr = 1'b1; addr = a; wdata = d;
        end
        cyc();
        wr = 1'b0; wr4 = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        rd4 = 1'b0; wr4 = 1'b0; addr4 = '0; wdata4 = '0;

        // reset held for two edges
        cyc();
        cyc();
        reset = 1'b1;
        rd_chk(0, A_TH, 32'h0, "rst_th");
        rd_chk(0, A_TL, 32'h0, "rst_tl");
        rd_chk(0, A_TC, 32'h0, "rst_tcon");
        rd_chk(0, A_ST, 32'h0, "rst_systick");
        chk("rst_irq", {31'd0, irq}, 32'd0);
        cyc();
        rd_chk(0, A_ST, 32'h1, "systick_1");

        // count and reload
        wr_reg(0, A_TH, 32'hFFFF_FFFD);
        wr_reg(0, A_TL, 32'hFFFF_FFFE);
        wr_reg(0, A_TC, 32'h3);
        rd_chk(0, A_TL, 32'hFFFF_FFFE, "tl_after_en");
        rd_chk(0, A_TC, 32'h3, "tcon_3");
        cyc();
        rd_chk(0, A_TL, 32'hFFFF_FFFF, "tl_ffff");
        chk("irq_pre_ovf", {31'd0, irq}, 32'd0);
        cyc();
        rd_chk(0, A_TL, 32'hFFFF_FFFD, "tl_reload");
        rd_chk(0, A_TC, 32'h7, "tcon_ovf");
        chk("irq_ovf", {31'd0, irq}, 32'd1);
        cyc();
        rd_chk(0, A_TL, 32'hFFFF_FFFE, "tl_post_reload");
        chk("irq_held", {31'd0, irq}, 32'd1);

        // clear race: write TCON=3 on the overflow edge
        wr_reg(0, A_TC, 32'h0);
        rd_chk(0, A_TL, 32'hFFFF_FFFF, "tl_stop");
        chk("irq_clr0", {31'd0, irq}, 32'd0);
        wr_reg(0, A_TC, 32'h3);
        rd_chk(0, A_TL, 32'hFFFF_FFFF, "tl_hold_en0");
        wr_reg(0, A_TC, 32'h3);
        rd_chk(0, A_TC, 32'h7, "race_tcon");
        rd_chk(0, A_TL, 32'hFFFF_FFFD, "race_tl");
        chk("race_irq", {31'd0, irq}, 32'd1);
        wr_reg(0, A_TC, 32'h3);
        chk("clr_irq", {31'd0, irq}, 32'd0);
        rd_chk(0, A_TC, 32'h3, "clr_tcon");
        wr_reg(0, A_TC, 32'h0);

        // read and write together: read shows pre-edge value
        rd = 1'b1; wr = 1'b1; addr = A_TH; wdata = 32'h0000_1234;
        #1;
        chk("rw_old_th", rdata, 32'hFFFF_FFFD);
        cyc();
        rd = 1'b0; wr = 1'b0;
        rd_chk(0, A_TH, 32'h0000_1234, "rw_new_th");

        // decode
        wr_reg(0, A_TC, 32'h2);
        rd_chk(0, A_TC, 32'h2, "tcon_2");
        rd_chk(0, BASE + 32'h10, 32'h0, "miss_hi");
        rd_chk(0, BASE + 32'h2, 32'h0, "misalign");
        rd_chk(0, 32'h0000_0008, 32'h0, "miss_lo");
        addr = A_TH;
        #1;
        chk("no_memread", rdata, 32'h0);
        wr_reg(0, BASE + 32'h1, 32'hAA);
        wr_reg(0, 32'h0000_0000, 32'h77);
        rd_chk(0, A_TH, 32'h0000_1234, "th_wr_dropped");
        rd = 1'b1; addr = A_ST;
        #1;
        st0 = rdata;
        rd = 1'b0;
        wr_reg(0, A_ST, 32'h55);
        rd_chk(0, A_ST, st0 + 32'd1, "systick_wr_ign");
        cyc();
        rd_chk(0, A_ST, st0 + 32'd2, "systick_run");

        // reset mid-count beats a same-edge TL write
        wr_reg(0, A_TC, 32'h7);
        chk("irq_sw_set", {31'd0, irq}, 32'd1);
        reset = 1'b0; wr = 1'b1; addr = A_TL; wdata = 32'h5;
        cyc();
        reset = 1'b1; wr = 1'b0;
        chk("rst2_irq", {31'd0, irq}, 32'd0);
        rd_chk(0, A_TH, 32'h0, "rst2_th");
        rd_chk(0, A_TL, 32'h0, "rst2_tl");
        rd_chk(0, A_TC, 32'h0, "rst2_tcon");
        rd_chk(0, A_ST, 32'h0, "rst2_systick");

        // PRESCALE=4 instance
        wr_reg(1, A_TL, 32'h0);
        wr_reg(1, A_TC, 32'h1);
        cyc(); cyc(); cyc();
        rd_chk(1, A_TL, 32'h0, "p4_tl0");
        cyc();
        rd_chk(1, A_TL, 32'h1, "p4_tl1");
        cyc(); cyc(); cyc();
        rd_chk(1, A_TL, 32'h1, "p4_tl1_hold");
        cyc();
        rd_chk(1, A_TL, 32'h2, "p4_tl2");
        cyc();
        wr_reg(1, A_TC, 32'h0);
        cyc(); cyc();
        wr_reg(1, A_TC, 32'h1);
        rd_chk(1, A_TL, 32'h2, "p4_paused");
        cyc();
        rd_chk(1, A_TL, 32'h2, "p4_resume");
        cyc();
        rd_chk(1, A_TL, 32'h3, "p4_tl3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
